// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data wins arbitration unless fetch has lost STARVE_MAX times in a row; hung accesses time out.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  output logic              busy,
  output logic              err,
  output logic [1:0]        fsm_state
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [SW-1:0]     starve_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_wr;

  logic dreq, grant_d, grant_i, timeout_hit;

  assign dreq        = dREN | dWEN;
  assign grant_d     = (state == IDLE) && dreq && (starve_cnt < STARVE_LIM);
  assign grant_i     = (state == IDLE) && !grant_d && iREN;
  // tmo_cnt counts prior stalled cycles, so the TIMEOUT-th stalled cycle aborts
  assign timeout_hit = (state != IDLE) && !ramready && (tmo_cnt == TMO_LAST);
  assign fsm_state   = RST ? 2'd0 : state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_wr     <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_d) begin
        lat_addr <= daddr;
        lat_data <= dstore;
        lat_wr   <= dWEN;
      end else if (grant_i) begin
        lat_addr <= iaddr;
        lat_data <= '0;
        lat_wr   <= 1'b0;
      end
      if (state == IDLE) begin
        tmo_cnt <= '0;
        if (grant_i || !iREN) starve_cnt <= '0;
        else if (grant_d)     starve_cnt <= starve_cnt + SW'(1);
      end else if (!ramready) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    iwait      = iREN;
    dwait      = dreq;
    iload      = '0;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    busy       = 1'b0;
    err        = 1'b0;
    if (RST) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d)      next_state = DACC;
          else if (grant_i) next_state = IACC;
        end
        IACC: begin
          busy    = 1'b1;
          ramREN  = 1'b1;
          ramaddr = lat_addr;
          if (ramready) begin
            iload      = ramload;
            iwait      = 1'b0;
            next_state = IDLE;
          end else if (timeout_hit) begin
            err        = 1'b1;
            iwait      = 1'b0;
            next_state = IDLE;
          end
        end
        DACC: begin
          busy     = 1'b1;
          ramREN   = !lat_wr;
          ramWEN   = lat_wr;
          ramaddr  = lat_addr;
          ramstore = lat_data;
          if (ramready) begin
            dload      = lat_wr ? '0 : ramload;
            dwait      = 1'b0;
            next_state = IDLE;
          end else if (timeout_hit) begin
            err        = 1'b1;
            dwait      = 1'b0;
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, each cycle
// compared against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int SM  = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, busy, err;
  logic [1:0]  fsm_state;

  int n_assert = 0;
  int n_fail   = 0;

  // model: owner 0 = none, 1 = fetch, 2 = data
  int          m_owner, m_starve, m_tcnt;
  logic [31:0] m_addr, m_data;
  logic        m_wr;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM), .TIMEOUT(TMO)) dut (
    .CLK(clk), .RST(rst),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready),
    .busy(busy), .err(err), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_starve = 0; m_tcnt = 0;
    m_addr = '0; m_data = '0; m_wr = 1'b0;
  endtask

  // Called just after negedge with inputs set: check outputs, then advance one clock.
  task automatic step();
    logic [31:0] e_iload, e_dload, e_addr, e_store;
    logic        e_iwait, e_dwait, e_ren, e_wen, e_busy, e_err;
    logic [1:0]  e_st;
    bit          done, to;
    #1;
    e_iload = '0; e_dload = '0; e_addr = '0; e_store = '0;
    e_iwait = iREN; e_dwait = dREN | dWEN;
    e_ren = 1'b0; e_wen = 1'b0; e_busy = 1'b0; e_err = 1'b0; e_st = 2'd0;
    done = 1'b0; to = 1'b0;
    if (!rst && m_owner != 0) begin
      e_busy = 1'b1;
      e_addr = m_addr;
      e_st   = 2'(m_owner);
      done   = ramready;
      to     = !ramready && (m_tcnt + 1 == TMO);
      e_err  = to;
      if (m_owner == 1) begin
        e_ren = 1'b1;
        if (done || to) e_iwait = 1'b0;
        if (done) e_iload = ramload;
      end else begin
        e_ren   = !m_wr;
        e_wen   = m_wr;
        e_store = m_data;
        if (done || to) e_dwait = 1'b0;
        if (done && !m_wr) e_dload = ramload;
      end
    end
    chk("iload", iload, e_iload);
    chk("iwait", 32'(iwait), 32'(e_iwait));
    chk("dload", dload, e_dload);
    chk("dwait", 32'(dwait), 32'(e_dwait));
    chk("ramREN", 32'(ramREN), 32'(e_ren));
    chk("ramWEN", 32'(ramWEN), 32'(e_wen));
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("err", 32'(err), 32'(e_err));
    chk("state", 32'(fsm_state), 32'(e_st));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (m_owner == 0) begin
      if ((dREN || dWEN) && m_starve < SM) begin
        m_owner = 2; m_addr = daddr; m_data = dstore; m_wr = dWEN; m_tcnt = 0;
        m_starve = iREN ? m_starve + 1 : 0;
      end else if (iREN) begin
        m_owner = 1; m_addr = iaddr; m_data = '0; m_wr = 1'b0; m_tcnt = 0;
        m_starve = 0;
      end else begin
        m_starve = 0;
      end
    end else if (done || to) begin
      m_owner = 0;
    end else begin
      m_tcnt++;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    model_reset();
    @(negedge clk);
    // reset: waits mirror requests, everything else held low
    for (int i = 0; i < 4; i++) begin
      iREN = 1'($urandom_range(0, 1)); dREN = 1'($urandom_range(0, 1));
      dWEN = 1'($urandom_range(0, 1)); ramready = 1'($urandom_range(0, 1));
      ramload = $urandom;
      step();
    end
    rst = 1'b0;
    quiet();
    step();

    // single fetch, ready on third access cycle
    iREN = 1; iaddr = 32'h100;
    step();
    step();
    step();
    ramready = 1; ramload = 32'hDEADBEEF;
    step();
    iREN = 0; ramready = 0;
    step();
    chk("fetch_done_state", 32'(fsm_state), 32'd0);

    // simultaneous requests: data write first, bubble, then fetch
    iREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'h55; ramready = 1; ramload = 32'h1234;
    step();
    step();
    dWEN = 0;
    repeat (3) step();
    quiet();
    step();

    // starvation: fetch held, data always requesting
    iREN = 1; iaddr = 32'h400; dREN = 1; daddr = 32'h500; ramready = 1;
    for (int i = 0; i < 16; i++) begin
      ramload = $urandom;
      step();
    end
    quiet();
    step();

    // timeout on a hung data read
    dREN = 1; daddr = 32'h600;
    for (int i = 0; i < 12; i++) begin
      if (i == 9) dREN = 0;
      step();
    end
    quiet();
    step();

    // reset in the second fetch access cycle, fetch held through it
    iREN = 1; iaddr = 32'h700;
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    chk("post_rst_ramREN", 32'(ramREN), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    step();
    step();
    ramready = 1;
    step();
    quiet();
    step();

    // address change mid-access is ignored
    dREN = 1; daddr = 32'h200;
    step();
    step();
    daddr = 32'h300;
    step();
    chk("latched_addr", ramaddr, 32'h200);
    ramready = 1; ramload = 32'hCAFEF00D;
    step();
    quiet();
    step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      iREN     = ($urandom_range(0, 3) != 0);
      dREN     = ($urandom_range(0, 2) == 0);
      dWEN     = ($urandom_range(0, 3) == 0);
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      ramready = ($urandom_range(0, 9) < 3);
      step();
    end
    rst = 0;
    quiet();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
